// File: rtl/fnd_scan_controller.sv
// Multiplexed seven-segment scan controller with tear-free frame loading.
// Define FND_ZERO_BLANK_EN to blank leading zero digits.
module fnd_scan_controller #(
  parameter int DIGITS  = 4,
  parameter int CLK_DIV = 100000
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_en,
  input  logic                  i_load,
  input  logic [4*DIGITS-1:0]   i_value,
  input  logic [DIGITS-1:0]     i_dp,
  output logic [DIGITS-1:0]     o_digit,
  output logic [7:0]            o_font,
  output logic                  o_pending,
  output logic                  o_tick,
  output logic                  o_frame
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IW = $clog2(DIGITS);

  logic [PW-1:0]         presc_q, presc_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [4*DIGITS-1:0]   shadow_val_q, shadow_val_d;
  logic [DIGITS-1:0]     shadow_dp_q, shadow_dp_d;
  logic [4*DIGITS-1:0]   disp_val_q, disp_val_d;
  logic [DIGITS-1:0]     disp_dp_q, disp_dp_d;
  logic                  pending_q, pending_d;
  logic [DIGITS-1:0]     digit_q, digit_d;
  logic [7:0]            font_q, font_d;
  logic                  tick_q, tick_d;
  logic                  frame_q, frame_d;

  logic                  wrap;
  logic [3:0]            nib;
  logic                  dp_sel;
  logic                  blank;
  logic [DIGITS-1:0]     lz;
`ifdef FND_ZERO_BLANK_EN
  logic                  hz;
`endif

  function automatic logic [7:0] seg7(input logic [3:0] n);
    logic [7:0] s;
    case (n)
      4'h0: s = 8'hC0;
      4'h1: s = 8'hF9;
      4'h2: s = 8'hA4;
      4'h3: s = 8'hB0;
      4'h4: s = 8'h99;
      4'h5: s = 8'h92;
      4'h6: s = 8'h82;
      4'h7: s = 8'hF8;
      4'h8: s = 8'h80;
      4'h9: s = 8'h90;
      4'hA: s = 8'h88;
      4'hB: s = 8'h83;
      4'hC: s = 8'hC6;
      4'hD: s = 8'hA1;
      4'hE: s = 8'h86;
      default: s = 8'h8E;
    endcase
    return s;
  endfunction

  always_comb begin
    tick_d  = (presc_q == PW'(CLK_DIV - 1));
    wrap    = tick_d && (idx_q == IW'(DIGITS - 1));
    frame_d = wrap;
    presc_d = tick_d ? '0 : presc_q + PW'(1);
    idx_d   = idx_q;
    if (tick_d) idx_d = wrap ? '0 : idx_q + IW'(1);

    shadow_val_d = shadow_val_q;
    shadow_dp_d  = shadow_dp_q;
    disp_val_d   = disp_val_q;
    disp_dp_d    = disp_dp_q;
    pending_d    = pending_q;
    if (i_load) begin
      shadow_val_d = i_value;
      shadow_dp_d  = i_dp;
    end
    // A load on the boundary edge bypasses the shadow stage entirely.
    if (wrap) begin
      disp_val_d = i_load ? i_value : shadow_val_q;
      disp_dp_d  = i_load ? i_dp : shadow_dp_q;
      pending_d  = 1'b0;
    end else if (i_load) begin
      pending_d = 1'b1;
    end

    lz = '0;
`ifdef FND_ZERO_BLANK_EN
    hz = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      hz    = hz & (disp_val_d[4*k +: 4] == 4'h0);
      lz[k] = hz;
    end
`endif

    nib    = '0;
    dp_sel = 1'b0;
    blank  = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx_d == IW'(k)) begin
        nib    = disp_val_d[4*k +: 4];
        dp_sel = disp_dp_d[k];
        blank  = lz[k];
      end
    end

    font_d = blank ? 8'hFF : seg7(nib);
    if (dp_sel) font_d[7] = 1'b0;
    digit_d = ~(DIGITS'(1) << idx_d);
    if (!i_en) begin
      font_d  = 8'hFF;
      digit_d = '1;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      presc_q      <= '0;
      idx_q        <= '0;
      shadow_val_q <= '0;
      shadow_dp_q  <= '0;
      disp_val_q   <= '0;
      disp_dp_q    <= '0;
      pending_q    <= 1'b0;
      digit_q      <= '1;
      font_q       <= 8'hFF;
      tick_q       <= 1'b0;
      frame_q      <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      shadow_val_q <= shadow_val_d;
      shadow_dp_q  <= shadow_dp_d;
      disp_val_q   <= disp_val_d;
      disp_dp_q    <= disp_dp_d;
      pending_q    <= pending_d;
      digit_q      <= digit_d;
      font_q       <= font_d;
      tick_q       <= tick_d;
      frame_q      <= frame_d;
    end
  end

  assign o_digit   = digit_q;
  assign o_font    = font_q;
  assign o_pending = pending_q;
  assign o_tick    = tick_q;
  assign o_frame   = frame_q;

endmodule

// File: doc/fnd_scan_controller.md
# fnd_scan_controller

Parametrised multiplexed seven-segment (FND) display controller: holds a DIGITS-wide hex value, time-multiplexes it one digit at a time with a built-in prescaler, and drives the digit-select and font lines directly. It supersedes the separate combinational digit-select and BCD-to-font decoders by adding scan timing, tear-free value loading, per-digit decimal points and an optional leading-zero blank. Sits between the datapath's display value and the board FND pins.

## Interface
- DIGITS, 4, number of digits scanned (2..8)
- CLK_DIV, 100000, clock cycles each digit stays selected (≥1)
- i_clk  in  1  system clock, rising edge
- i_reset_n  in  1  reset, asynchronous, active-low
- i_en  in  1  display enable; 0 blanks outputs, scanning continues
- i_load  in  1  one-cycle strobe: capture i_value/i_dp
- i_value  in  4*DIGITS  hex nibbles, nibble k = digit k (k=0 rightmost)
- i_dp  in  DIGITS  decimal-point request per digit, 1 = lit
- o_digit  out  DIGITS  digit select, active-low one-hot
- o_font  out  8  segments {dp,g,f,e,d,c,b,a}, active-low
- o_pending  out  1  loaded value not yet on display
- o_tick  out  1  one-cycle pulse on every digit advance
- o_frame  out  1  one-cycle pulse when scan wraps to digit 0

## Operation
- Prescaler counts 0..CLK_DIV-1; at CLK_DIV-1 it wraps and asserts internal tick; scan index idx advances modulo DIGITS.
- Frame boundary = tick with idx==DIGITS-1 (idx wraps to 0).
- Load: i_load=1 writes i_value/i_dp into shadow register, sets o_pending. Shadow copied to display register only at a frame boundary, then o_pending clears. Repeated loads before boundary: last one wins.
- i_load coinciding with frame-boundary edge: i_value/i_dp go straight to display register and shadow; o_pending stays 0.
- Font (hex, active-low, bit7=1): 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8, 8 80, 9 90, A 88, b 83, C C6, d A1, E 86, F 8E. dp requested clears bit 7.
- o_digit = ~(1<<idx) when i_en=1; all ones when i_en=0. o_font = 8'hFF when i_en=0.
- i_en does not affect prescaler, idx, loading or o_tick/o_frame.

## Timing
- Reset (async assert, sync-released use): prescaler 0, idx 0, shadow/display 0, o_pending 0, o_tick 0, o_frame 0, o_digit all ones, o_font 8'hFF.
- o_digit/o_font registered: reflect idx and display register one cycle after they change; first valid drive one cycle after reset release (digit 0, font C0 if i_en=1).
- o_tick/o_frame registered, asserted the cycle after the prescaler wrap edge, coincident with updated o_digit.
- Dwell per digit exactly CLK_DIV cycles; frame period DIGITS*CLK_DIV cycles. CLK_DIV=1: idx advances every cycle.
- o_pending rises the cycle after i_load, falls the cycle after the boundary edge; new font visible on digit 0 in that same cycle.
- i_en toggles take effect on outputs one cycle later.
- Reset mid-scan or with pending load: all state cleared, pending load discarded.

## Configuration
- FND_ZERO_BLANK_EN defined: leading-zero suppression. Digit k (k≥1) whose nibble and all higher nibbles are 0 outputs segments off (font 8'h7F if its dp lit, else 8'hFF); digit 0 always shown. Select lines unchanged.
- Undefined: all digits always decoded, zeros shown as C0.

## Test plan
- DIGITS=4, CLK_DIV=4, reset release, i_en=1 -> o_digit 1110,1101,1011,0111 each for 4 cycles, repeating; o_frame every 16 cycles; o_font C0 throughout.
- Load 16'h1A5F mid-frame -> o_pending=1 until boundary; then digit0 8E, digit1 92, digit2 88, digit3 F9; o_pending=0.
- Load 16'h0000 then 16'h2345 before boundary -> only 2345 appears (B0,99... per digit); loads at boundary edge -> immediate, o_pending never rises.
- i_dp=4'b0100 with value 16'h8888 -> digit2 font 00, others 80; i_en=0 -> o_digit 1111, o_font FF, o_frame still pulsing.
- FND_ZERO_BLANK_EN, value 16'h0050 -> digit3,2 FF, digit1 92, digit0 C0; value 0 -> only digit0 C0. Without macro -> C0 on zeros.
- Assert i_reset_n low mid-dwell with pending load -> outputs immediately 1111/FF, after release scan restarts at digit 0 with value 0.
